// File: rtl/fb_pkg.sv
// Shared definitions for the HUB75 framebuffer path.
//   COLS/ROWS   : panel geometry; ROWS/2 rows per memory bank
//   SYNC        : packet header byte
//   state_e     : stream loader FSM states
//   R/G/B_*     : RGB565 field positions, shared with the scan-out colour decoder
package fb_pkg;

    localparam int unsigned COLS  = 64;
    localparam int unsigned ROWS  = 32;
    localparam int unsigned COL_W = 6;
    localparam logic [7:0]  SYNC  = 8'hA5;

    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ROW,
        ST_COL,
        ST_CNT,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_DISCARD
    } state_e;

    // Pixel count is usable only if it names between 1 and COLS pixels.
    function automatic logic cnt_ok(input logic [7:0] cnt);
        return (cnt != 8'd0) && (cnt <= 8'(COLS));
    endfunction

endpackage

// File: rtl/fb_stream_loader.sv
// Framebuffer writer: parses SYNC/ROW/COL/CNT pixel-run packets from a byte
// stream and writes RGB565 words into the two display banks.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data/in_valid  stream byte and its valid; consumed when in_ready is high
//   in_ready          high whenever out of reset (one byte per clock)
//   wen0/wen1         registered write strobes, bank0 rows 0..15, bank1 rows 16..31
//   waddr/wdata       {row[3:0], col[5:0]} and RGB565 word; hold when no write
//   pkt_done          pulses with the last write of a packet
//   pkt_err           pulses when a header has a bad count or out-of-range row
module fb_stream_loader
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wen0,
    output logic        wen1,
    output logic [9:0]  waddr,
    output logic [15:0] wdata,
    output logic        pkt_done,
    output logic        pkt_err
);

    state_e           state_q, state_d;
    logic [7:0]       row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       rem_q, rem_d;
    logic [7:0]       hi_q, hi_d;
    logic             ready_q, ready_d;
    logic             wen0_q, wen0_d;
    logic             wen1_q, wen1_d;
    logic [9:0]       waddr_q, waddr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;

    // ready_q comes up one clock after reset release and then stays high.
    assign accept = in_valid && ready_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        ready_d = 1'b1;
        wen0_d  = 1'b0;
        wen1_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (accept) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (in_data == SYNC) state_d = ST_ROW;
                end
                ST_ROW: begin
                    row_d   = in_data;
                    state_d = ST_COL;
                end
                ST_COL: begin
                    col_d   = in_data[COL_W-1:0];
                    state_d = ST_CNT;
                end
                ST_CNT: begin
                    if (!cnt_ok(in_data)) begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end else if (row_q >= 8'(ROWS)) begin
                        // Count <= COLS, so twice it still fits in 8 bits.
                        err_d   = 1'b1;
                        rem_d   = {in_data[6:0], 1'b0};
                        state_d = ST_DISCARD;
                    end else begin
                        rem_d   = in_data;
                        state_d = ST_PIX_HI;
                    end
                end
                ST_PIX_HI: begin
                    hi_d    = in_data;
                    state_d = ST_PIX_LO;
                end
                ST_PIX_LO: begin
                    wen1_d  = row_q[4];
                    wen0_d  = ~row_q[4];
                    waddr_d = {row_q[3:0], col_q};
                    wdata_d = {hi_q, in_data};
                    done_d  = (rem_q == 8'd1);
                    rem_d   = rem_q - 8'd1;
                    col_d   = col_q + 1'b1;
                    state_d = (rem_q == 8'd1) ? ST_HUNT : ST_PIX_HI;
                end
                ST_DISCARD: begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            row_q   <= '0;
            col_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            ready_q <= 1'b0;
            wen0_q  <= 1'b0;
            wen1_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            ready_q <= ready_d;
            wen0_q  <= wen0_d;
            wen1_q  <= wen1_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready = ready_q;
    assign wen0     = wen0_q;
    assign wen1     = wen1_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign pkt_done = done_q;
    assign pkt_err  = err_q;

endmodule

// File: tb/tb_fb_stream_loader.sv
// Self-checking bench for fb_stream_loader: directed vector table, reset and
// back-to-back sequences, then random packets against a packet-level model.
module tb_fb_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wen0, wen1;
    logic [9:0]  waddr;
    logic [15:0] wdata;
    logic        pkt_done, pkt_err;

    fb_stream_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wen0(wen0), .wen1(wen1), .waddr(waddr),
        .wdata(wdata), .pkt_done(pkt_done), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bank;
        logic [9:0]  addr;
        logic [15:0] data;
        logic        done;
        int          cyc;
    } wr_t;

    typedef struct packed {
        logic [127:0]      b;      // bytes left-justified, first byte in [127:120]
        logic [7:0]        n;
        logic [1:0]        nerr;
        logic [1:0]        nwr;
        logic [1:0]        bank;
        logic [1:0][9:0]   addr;
        logic [1:0][15:0]  data;
    } vec_t;

    wr_t  cap[$];
    wr_t  expq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   err_seen = 0;
    int   exp_err = 0;
    int   both_cnt = 0;
    int   stray_done = 0;
    int   ready_drop = 0;
    logic watch_ready = 1'b0;
    logic [15:0] pix [64];

    // Outputs change on posedge; sample them on the following negedge.
    always @(negedge clk) begin
        if (wen0 || wen1) cap.push_back('{wen1, waddr, wdata, pkt_done, cyc});
        if (wen0 && wen1) both_cnt++;
        if (pkt_done && !(wen0 || wen1)) stray_done++;
        if (pkt_err) err_seen++;
        if (watch_ready && rst_n && !in_ready) ready_drop++;
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int unsigned w = 0;
        @(negedge clk); #1;
        while (!in_ready && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1");
        end
        in_valid = 1'b1;
        in_data  = b;
        last_acc = cyc;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
            in_data  = $urandom_range(0, 255);
        end
    endtask

    task automatic clear_phase();
        cap.delete();
        expq.delete();
        err_seen = 0;
        exp_err  = 0;
    endtask

    task automatic compare_phase(input string name);
        int n;
        chk({name, "_nwr"}, cap.size(), expq.size());
        chk({name, "_nerr"}, err_seen, exp_err);
        n = (cap.size() < expq.size()) ? cap.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_bank"}, cap[i].bank, expq[i].bank);
            chk({name, "_addr"}, cap[i].addr, expq[i].addr);
            chk({name, "_data"}, cap[i].data, expq[i].data);
            chk({name, "_done"}, cap[i].done, expq[i].done);
        end
        clear_phase();
    endtask

    // Packet-level reference: what a header plus pixel list should produce.
    task automatic model_pkt(input int row, input int col, input int cnt);
        if (cnt == 0 || cnt > 64 || row >= 32) begin
            exp_err++;
        end else begin
            for (int i = 0; i < cnt; i++)
                expq.push_back('{row / 16, 10'((row % 16) * 64 + (col + i) % 64),
                                 pix[i], i == cnt - 1, 0});
        end
    endtask

    task automatic rand_pkt();
        int kind, row, col, cnt, junk;
        logic [7:0] j;
        kind = $urandom_range(0, 9);
        row  = (kind == 7) ? $urandom_range(32, 255) : $urandom_range(0, 31);
        col  = $urandom_range(0, 255);
        if (kind == 8)      cnt = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 255);
        else if (kind == 9) cnt = 64;
        else                cnt = $urandom_range(1, 6);
        for (int i = 0; i < 64; i++) pix[i] = 16'($urandom);
        junk = $urandom_range(0, 2);
        for (int i = 0; i < junk; i++) begin
            j = 8'($urandom_range(0, 255));
            if (j == 8'hA5) j = 8'h00;
            send(j);
        end
        send(8'hA5); send(8'(row)); send(8'(col)); send(8'(cnt));
        if (cnt >= 1 && cnt <= 64) begin
            if (row >= 32) begin
                for (int i = 0; i < 2 * cnt; i++) send(8'($urandom_range(0, 255)));
            end else begin
                for (int i = 0; i < cnt; i++) begin
                    send(pix[i][15:8]);
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send(pix[i][7:0]);
                end
            end
        end
        model_pkt(row, col, cnt);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    endtask

    vec_t tv [5];

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        tv[0] = '0; tv[0].b = 128'hA5_03_00_02_F8_00_07_E0_00000000_00000000; tv[0].n = 8;
        tv[0].nwr = 2; tv[0].addr[0] = 10'h0C0; tv[0].data[0] = 16'hF800;
        tv[0].addr[1] = 10'h0C1; tv[0].data[1] = 16'h07E0;
        tv[1] = '0; tv[1].b = 128'hA5_14_3F_02_00_1F_FF_FF_00000000_00000000; tv[1].n = 8;
        tv[1].nwr = 2; tv[1].bank = 2'b11; tv[1].addr[0] = 10'h13F; tv[1].data[0] = 16'h001F;
        tv[1].addr[1] = 10'h100; tv[1].data[1] = 16'hFFFF;
        tv[2] = '0; tv[2].b = 128'hA5_28_00_02_11_22_A5_44_A5_00_00_01_12_34_0000; tv[2].n = 14;
        tv[2].nerr = 1; tv[2].nwr = 1; tv[2].addr[0] = 10'h000; tv[2].data[0] = 16'h1234;
        tv[3] = '0; tv[3].b = 128'hA5_00_00_00_05_A5_00_00_41_05_A5_01_02_01_AB_CD; tv[3].n = 16;
        tv[3].nerr = 2; tv[3].nwr = 1; tv[3].addr[0] = 10'h042; tv[3].data[0] = 16'hABCD;
        tv[4] = '0; tv[4].b = 128'hA5_1F_C5_01_A5_A5_0000_00000000_00000000; tv[4].n = 6;
        tv[4].nwr = 1; tv[4].bank = 2'b01; tv[4].addr[0] = 10'h3C5; tv[4].data[0] = 16'hA5A5;

        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_wen", {wen0, wen1, pkt_done, pkt_err}, 4'b0);
        chk("rst_addr_data", {waddr, wdata}, 26'h0);
        #1 rst_n = 1'b1;
        idle(2);
        chk("ready_after_rst", in_ready, 1'b1);
        clear_phase();

        // Directed vector table
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < int'(tv[v].n); k++) send(tv[v].b[127 - 8 * k -: 8]);
            idle(3);
            exp_err = int'(tv[v].nerr);
            for (int i = 0; i < int'(tv[v].nwr); i++)
                expq.push_back('{tv[v].bank[i], tv[v].addr[i], tv[v].data[i],
                                 i == int'(tv[v].nwr) - 1, 0});
            if (cap.size() > 0)
                chk($sformatf("vec%0d_latency", v), cap[cap.size() - 1].cyc, last_acc + 0);
            compare_phase($sformatf("vec%0d", v));
            last_acc = -1;
        end

        // Reset after PIX_HI drops the packet; junk byte after release is ignored
        send(8'hA5); send(8'h03); send(8'h00); send(8'h01); send(8'hF8);
        @(negedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_outputs", {wen0, wen1, pkt_done, pkt_err, in_ready}, 5'b0);
        #1 rst_n = 1'b1;
        idle(2);
        compare_phase("midrst_nowrite");
        send(8'h34); send(8'hA5); send(8'h02); send(8'h05); send(8'h01);
        send(8'h12); send(8'h34);
        idle(3);
        expq.push_back('{1'b0, 10'h085, 16'h1234, 1'b1, 0});
        compare_phase("postrst");

        // Back-to-back packets with in_valid held high throughout
        watch_ready = 1'b1;
        pix[0] = 16'h1357; pix[1] = 16'h2468;
        send(8'hA5); send(8'h11); send(8'h3E); send(8'h02);
        send(8'h13); send(8'h57); send(8'h24); send(8'h68);
        model_pkt(17, 62, 2);
        pix[0] = 16'hBEEF;
        send(8'hA5); send(8'h05); send(8'h07); send(8'h01); send(8'hBE); send(8'hEF);
        model_pkt(5, 7, 1);
        idle(3);
        watch_ready = 1'b0;
        chk("b2b_ready_const", ready_drop, 0);
        compare_phase("b2b");

        // Random packets against the reference model
        for (int p = 0; p < 60; p++) rand_pkt();
        idle(4);
        compare_phase("rand");

        chk("wen_exclusive", both_cnt, 0);
        chk("done_without_write", stray_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
